// File: rtl/func_result_serializer.sv
// -----------------------------------------------------------------------------
// func_result_serializer
//
// Purpose:
//   Downstream stage of the multi-function compute block. Accepts the six
//   parallel WIDTH-bit function results (arith, bool, case, nested, loop,
//   mixed) as one frame via valid/ready, buffers up to FIFO_DEPTH frames, and
//   emits each frame as six sequential beats (lane 0..5) on a narrow
//   valid/ready stream. Completed frames are counted; a flush request drops
//   buffered frames once the frame currently on the wire has finished.
//
// Parameters:
//   WIDTH      width of each result lane and of out_data
//   FIFO_DEPTH frames buffered (power of 2, >= 2)
//   CNT_W      width of frame_cnt (wraps silently)
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   frame handshake for res_* lanes
//   res_arith..res_mixed result lanes 0..5
//   flush               pulse: drop buffered frames after the current frame
//   out_valid/out_ready beat handshake
//   out_data/out_lane   registered beat value and its lane index
//   out_last            high on lane 5
//   frame_cnt           frames fully sent
//   busy                FSM not idle or FIFO not empty
//   sig                 (only with FUNC_SER_SIGNATURE_EN) rotate-XOR checksum
//                       of every accepted beat, cleared by a flush
//
// Optional feature macro: FUNC_SER_SIGNATURE_EN
// -----------------------------------------------------------------------------
module func_result_serializer #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] res_arith,
  input  logic [WIDTH-1:0] res_bool,
  input  logic [WIDTH-1:0] res_case,
  input  logic [WIDTH-1:0] res_nested,
  input  logic [WIDTH-1:0] res_loop,
  input  logic [WIDTH-1:0] res_mixed,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_lane,
  output logic             out_last,
  output logic [CNT_W-1:0] frame_cnt,
`ifdef FUNC_SER_SIGNATURE_EN
  output logic [WIDTH-1:0] sig,
`endif
  output logic             busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   FULL_CNT  = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [2:0]       LAST_LANE = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  // One FIFO entry holds all six lanes; lane 0 (arith) in the low slot.
  typedef logic [5:0][WIDTH-1:0] frame_t;

  state_e             state_q, state_d;
  frame_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [2:0]         lane_idx_q, lane_idx_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic               flush_pend_q, flush_pend_d;
  logic               push;
  logic               beat;

  // A full FIFO refuses input even when a pop happens in the same cycle.
  assign in_ready = (count_q != FULL_CNT) && (state_q != FLUSH);
  assign push     = in_valid && in_ready;
  assign beat     = (state_q == SEND) && out_ready;

  assign out_valid = (state_q == SEND);
  assign out_data  = out_data_q;
  assign out_lane  = lane_idx_q;
  assign out_last  = (lane_idx_q == LAST_LANE);
  assign frame_cnt = frame_cnt_q;
  assign busy      = (state_q != IDLE) || (count_q != '0);

  // NOTE: every variable driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    lane_idx_d   = lane_idx_q;
    out_data_d   = out_data_q;
    frame_cnt_d  = frame_cnt_q;
    flush_pend_d = flush_pend_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      count_d  = count_q + CNT_ONE;
    end

    unique case (state_q)
      IDLE: begin
        // A frame pushed this cycle is not yet visible; flush on an empty
        // FIFO is a no-op, which keeps a frame pushed alongside it.
        if (count_q != '0) begin
          if (flush) begin
            state_d = FLUSH;
          end else begin
            state_d    = SEND;
            lane_idx_d = '0;
            out_data_d = mem_q[rd_ptr_q][0];
          end
        end
      end

      SEND: begin
        if (flush) flush_pend_d = 1'b1;
        if (out_ready) begin
          if (lane_idx_q != LAST_LANE) begin
            lane_idx_d = lane_idx_q + 3'd1;
            out_data_d = mem_q[rd_ptr_q][lane_idx_q + 3'd1];
          end else begin
            rd_ptr_d    = rd_ptr_q + PTR_ONE;
            count_d     = count_d - CNT_ONE;
            lane_idx_d  = '0;
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
            if (flush_pend_q || flush) begin
              state_d = FLUSH;
            end else if (count_d != '0) begin
              state_d = SEND;
              // If the only remaining frame is the one being pushed right
              // now, its lane 0 is taken from the inputs, since the memory
              // write lands on this same edge.
              out_data_d = (count_q == CNT_ONE) ? res_arith
                                                : mem_q[rd_ptr_q + PTR_ONE][0];
            end else begin
              state_d = IDLE;
            end
          end
        end
      end

      FLUSH: begin
        // in_ready is low here, so no push can collide with the clear.
        wr_ptr_d     = '0;
        rd_ptr_d     = '0;
        count_d      = '0;
        flush_pend_d = 1'b0;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      lane_idx_q   <= '0;
      out_data_q   <= '0;
      frame_cnt_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      lane_idx_q   <= lane_idx_d;
      out_data_q   <= out_data_d;
      frame_cnt_q  <= frame_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // NOTE: the frame storage is not reset; an entry is only read after it has
  // been written, and leaving it out of reset keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {res_mixed, res_loop, res_nested,
                          res_case, res_bool, res_arith};
    end
  end

`ifdef FUNC_SER_SIGNATURE_EN
  logic [WIDTH-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (state_q == FLUSH) begin
      sig_d = '0;
    end else if (beat) begin
      sig_d = {sig_q[WIDTH-2:0], sig_q[WIDTH-1]} ^ out_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sig_q <= '0;
    else     sig_q <= sig_d;
  end

  assign sig = sig_q;
`endif

endmodule

// File: tb/tb_func_result_serializer.sv
// -----------------------------------------------------------------------------
// tb_func_result_serializer
//
// Directed bench for func_result_serializer (WIDTH=8, FIFO_DEPTH=2, CNT_W=4).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge. A monitor records every accepted beat for order checks.
// -----------------------------------------------------------------------------
module tb_func_result_serializer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] res_arith, res_bool, res_case, res_nested, res_loop, res_mixed;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_lane;
  logic             out_last;
  logic [CNT_W-1:0] frame_cnt;
  logic             busy;
`ifdef FUNC_SER_SIGNATURE_EN
  logic [WIDTH-1:0] sig;
`endif

  func_result_serializer #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (2),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .res_arith  (res_arith),
    .res_bool   (res_bool),
    .res_case   (res_case),
    .res_nested (res_nested),
    .res_loop   (res_loop),
    .res_mixed  (res_mixed),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .out_last   (out_last),
    .frame_cnt  (frame_cnt),
`ifdef FUNC_SER_SIGNATURE_EN
    .sig        (sig),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] q_data [$];
  logic [2:0]       q_lane [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Beat monitor: a beat is accepted when valid and ready are both high.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_lane.push_back(out_lane);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q_data.delete();
    q_lane.delete();
  endtask

  task automatic set_lanes(input logic [5:0][7:0] l);
    res_arith  = l[0];
    res_bool   = l[1];
    res_case   = l[2];
    res_nested = l[3];
    res_loop   = l[4];
    res_mixed  = l[5];
  endtask

  // Called just after a rising edge; returns 1 unit after the accepting edge.
  task automatic push_frame(input string tag, input logic [5:0][7:0] l);
    logic acc;
    acc = 1'b0;
    set_lanes(l);
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) acc = 1'b1;
      step();
      if (acc) break;
    end
    in_valid = 1'b0;
    check({tag, "_accept"}, 32'(acc), 32'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    step();
    check({tag, "_idle"}, 32'(done), 32'd1);
  endtask

  function automatic logic [7:0] sig_model(input logic [7:0] s, input logic [7:0] d);
    return {s[6:0], s[7]} ^ d;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] base [3];
    logic [7:0] exp_sig;
    logic       acc;
    int         sz;

    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    set_lanes('0);
    do_reset();

    // ---------------- reset state ----------------
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_lane",  32'(out_lane),  32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
`ifdef FUNC_SER_SIGNATURE_EN
    check("rst_sig",       32'(sig),       32'd0);
`endif
    step();

    // ---------------- flush on empty IDLE is a no-op ----------------
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("noop_flush_in_ready", 32'(in_ready), 32'd1);
    check("noop_flush_busy",     32'(busy),     32'd0);
    step();

    // ---------------- single frame, out_ready=1 ----------------
    out_ready = 1'b1;
    push_frame("single", {8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11});
    @(negedge clk);
    check("single_latency_valid", 32'(out_valid), 32'd0);
    check("single_latency_busy",  32'(busy),      32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("single_valid_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("single_data_%0d", i),  32'(out_data),  32'((i + 1) * 8'h11));
      check($sformatf("single_lane_%0d", i),  32'(out_lane),  32'(i));
      check($sformatf("single_last_%0d", i),  32'(out_last),  32'(i == 5));
    end
    @(negedge clk);
    check("single_done_valid", 32'(out_valid), 32'd0);
    check("single_frame_cnt",  32'(frame_cnt), 32'd1);
    check("single_busy",       32'(busy),      32'd0);
    step();

    // ---------------- backpressure and full ----------------
    do_reset();
    out_ready = 1'b0;
    push_frame("bp_a", {8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1, 8'hA0});
    push_frame("bp_b", {8'hB5, 8'hB4, 8'hB3, 8'hB2, 8'hB1, 8'hB0});
    @(negedge clk);
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    step();
    set_lanes({8'hC5, 8'hC4, 8'hC3, 8'hC2, 8'hC1, 8'hC0});
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_in_ready_%0d", i), 32'(in_ready),  32'd0);
      check($sformatf("bp_stall_valid_%0d", i),   32'(out_valid), 32'd1);
      check($sformatf("bp_stall_data_%0d", i),    32'(out_data),  32'hA0);
      check($sformatf("bp_stall_lane_%0d", i),    32'(out_lane),  32'd0);
      step();
    end
    out_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        check("bp_c_after_first_pop", 32'(frame_cnt), 32'd1);
      end
      step();
      if (acc) break;
    end
    in_valid = 1'b0;
    check("bp_c_accept", 32'(acc), 32'd1);
    wait_idle("bp", 100);
    check("bp_beat_count", 32'(q_data.size()), 32'd18);
    check("bp_frame_cnt",  32'(frame_cnt),     32'd3);
    base[0] = 8'hA0; base[1] = 8'hB0; base[2] = 8'hC0;
    sz = q_data.size();
    for (int f = 0; f < 3; f++) begin
      for (int l = 0; l < 6; l++) begin
        if (f * 6 + l < sz) begin
          check($sformatf("bp_data_f%0d_l%0d", f, l), 32'(q_data[f*6+l]), 32'(8'(base[f] + 8'(l))));
          check($sformatf("bp_lane_f%0d_l%0d", f, l), 32'(q_lane[f*6+l]), 32'(l));
        end
      end
    end

    // ---------------- mid-frame flush ----------------
    do_reset();
    out_ready = 1'b0;
    push_frame("fl_1", {8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10});
    push_frame("fl_2", {8'h25, 8'h24, 8'h23, 8'h22, 8'h21, 8'h20});
    out_ready = 1'b1;
    step();
    step();
    check("fl_at_lane2", 32'(out_lane), 32'd2);
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int l = 3; l < 6; l++) begin
      @(negedge clk);
      check($sformatf("fl_lane_%0d", l), 32'(out_lane), 32'(l));
      check($sformatf("fl_data_%0d", l), 32'(out_data), 32'(8'h10 + l));
    end
    @(negedge clk);
    check("fl_flush_valid",    32'(out_valid), 32'd0);
    check("fl_flush_in_ready", 32'(in_ready),  32'd0);
    @(negedge clk);
    check("fl_after_in_ready", 32'(in_ready),  32'd1);
    check("fl_after_busy",     32'(busy),      32'd0);
    check("fl_frame_cnt",      32'(frame_cnt), 32'd1);
`ifdef FUNC_SER_SIGNATURE_EN
    check("fl_sig_cleared",    32'(sig),       32'd0);
`endif
    repeat (10) step();
    check("fl_beat_count", 32'(q_data.size()), 32'd6);
    sz = q_data.size();
    for (int l = 0; l < 6; l++) begin
      if (l < sz) check($sformatf("fl_beat_%0d", l), 32'(q_data[l]), 32'(8'h10 + l));
    end

    // ---------------- flush together with a push into empty IDLE ----------------
    do_reset();
    out_ready = 1'b1;
    set_lanes({8'h75, 8'h74, 8'h73, 8'h72, 8'h71, 8'h70});
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    wait_idle("fp", 50);
    check("fp_frame_cnt",  32'(frame_cnt),     32'd1);
    check("fp_beat_count", 32'(q_data.size()), 32'd6);
    if (q_data.size() == 6) check("fp_last_beat", 32'(q_data[5]), 32'h75);

    // ---------------- reset mid-frame ----------------
    do_reset();
    out_ready = 1'b1;
    push_frame("rm", {8'h45, 8'h44, 8'h43, 8'h42, 8'h41, 8'h40});
    repeat (4) step();
    check("rm_at_lane3", 32'(out_lane), 32'd3);
    check("rm_at_data3", 32'(out_data), 32'h43);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sz = q_data.size();
    @(negedge clk);
    check("rm_out_valid", 32'(out_valid), 32'd0);
    check("rm_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rm_in_ready",  32'(in_ready),  32'd1);
    check("rm_out_data",  32'(out_data),  32'd0);
    check("rm_busy",      32'(busy),      32'd0);
    repeat (10) step();
    check("rm_no_more_beats", 32'(q_data.size()), 32'(sz));

    // ---------------- counter wrap (CNT_W=4) ----------------
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      push_frame($sformatf("wr_%0d", k), {6{8'(k)}});
      wait_idle($sformatf("wr_%0d", k), 50);
      if (k == 15) check("wr_cnt_15", 32'(frame_cnt), 32'd15);
      if (k == 16) check("wr_cnt_16", 32'(frame_cnt), 32'd0);
      if (k == 17) check("wr_cnt_17", 32'(frame_cnt), 32'd1);
    end
    check("wr_beat_count", 32'(q_data.size()), 32'd102);

`ifdef FUNC_SER_SIGNATURE_EN
    // ---------------- signature ----------------
    do_reset();
    out_ready = 1'b1;
    push_frame("sig", {6{8'h01}});
    wait_idle("sig", 50);
    exp_sig = 8'h00;
    for (int i = 0; i < 6; i++) exp_sig = sig_model(exp_sig, 8'h01);
    check("sig_value", 32'(sig), 32'(exp_sig));
`else
    exp_sig = 8'h00;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
